// File: rtl/regpairfile.sv
// regpairfile: byte/pair register file with a fixed-latency pair inc/dec engine.
//
// Pair p is register 2p (high byte) and register 2p+1 (low byte).
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-low reset
//   wrenb/wrpair/waddr  - write enable, pair-vs-byte select, byte address
//   wdata               - write data ({high,low} for pair writes, [D-1:0] for byte)
//   r1*/r2*             - two combinational byte read ports (0 when disabled)
//   rp*                 - combinational pair read port, {high,low}
//   incenb/decenb/ipadd - start a pair increment/decrement on pair ipadd
//   busy/done/carry     - engine active, completion pulse, wrap of last operation
module regpairfile #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 3,
  parameter int unsigned REGCOUNT = 2**ADDRSIZE,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrenb,
  input  logic                    wrpair,
  input  logic [ADDRSIZE-1:0]     waddr,
  input  logic [2*DATASIZE-1:0]   wdata,
  input  logic                    r1enb,
  input  logic [ADDRSIZE-1:0]     r1add,
  output logic [DATASIZE-1:0]     r1dat,
  input  logic                    r2enb,
  input  logic [ADDRSIZE-1:0]     r2add,
  output logic [DATASIZE-1:0]     r2dat,
  input  logic                    rpenb,
  input  logic [ADDRSIZE-2:0]     rpadd,
  output logic [2*DATASIZE-1:0]   rpdat,
  input  logic                    incenb,
  input  logic                    decenb,
  input  logic [ADDRSIZE-2:0]     ipadd,
  output logic                    busy,
  output logic                    done,
  output logic                    carry
);

  typedef enum logic [1:0] {StIdle, StLo, StHi} eng_state_e;

  eng_state_e          state_q, state_d;
  logic [DATASIZE-1:0] regs_q [REGCOUNT];
  logic [DATASIZE-1:0] regs_d [REGCOUNT];
  logic [ADDRSIZE-2:0] pair_q, pair_d;
  logic                dec_q, dec_d;
  logic                cin_q, cin_d;
  logic                carry_q, carry_d;
  logic                done_q, done_d;

  logic                busy_w;
  logic                wr_ok;
  logic                wr_sel  [REGCOUNT];
  logic [DATASIZE-1:0] wr_byte [REGCOUNT];
  logic [DATASIZE-1:0] view    [REGCOUNT];

  logic [ADDRSIZE-1:0] lo_idx, hi_idx;
  logic [DATASIZE-1:0] lo_val, hi_val;

  assign busy_w = (state_q != StIdle);
  // Any write whose pair index matches the engine's pair touches one of its
  // registers, so the whole write (byte or pair) is dropped.
  assign wr_ok  = wrenb && !(busy_w && (waddr[ADDRSIZE-1:1] == pair_q));

  assign lo_idx = {pair_q, 1'b1};
  assign hi_idx = {pair_q, 1'b0};
  assign lo_val = regs_q[lo_idx];
  assign hi_val = regs_q[hi_idx];

  // Per-register write decode: which registers the external write targets
  // and which byte of wdata each one receives.
  always_comb begin
    logic [ADDRSIZE-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(REGCOUNT); i++) begin
      idx = ADDRSIZE'(i);
      if (wrpair) begin
        wr_sel[i]  = (idx[ADDRSIZE-1:1] == waddr[ADDRSIZE-1:1]);
        wr_byte[i] = idx[0] ? wdata[DATASIZE-1:0] : wdata[2*DATASIZE-1:DATASIZE];
      end else begin
        wr_sel[i]  = (idx == waddr);
        wr_byte[i] = wdata[DATASIZE-1:0];
      end
    end
  end

  // Read view: stored contents, overridden by an accepted same-cycle write.
  always_comb begin
    for (int i = 0; i < int'(REGCOUNT); i++) begin
      view[i] = (BYPASS && wr_ok && wr_sel[i]) ? wr_byte[i] : regs_q[i];
    end
  end

  assign r1dat = r1enb ? view[r1add] : '0;
  assign r2dat = r2enb ? view[r2add] : '0;
  assign rpdat = rpenb ? {view[{rpadd, 1'b0}], view[{rpadd, 1'b1}]} : '0;

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    dec_d   = dec_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    regs_d  = regs_q;

    for (int i = 0; i < int'(REGCOUNT); i++) begin
      if (wr_ok && wr_sel[i]) begin
        regs_d[i] = wr_byte[i];
      end
    end

    case (state_q)
      StIdle: begin
        if (incenb ^ decenb) begin
          state_d = StLo;
          pair_d  = ipadd;
          dec_d   = decenb;
        end
      end
      StLo: begin
        regs_d[lo_idx] = dec_q ? lo_val - 1'b1 : lo_val + 1'b1;
        cin_d          = dec_q ? (lo_val == '0) : (lo_val == '1);
        state_d        = StHi;
      end
      StHi: begin
        // High byte is always rewritten so latency stays fixed at 2 cycles.
        regs_d[hi_idx] = dec_q ? hi_val - DATASIZE'(cin_q) : hi_val + DATASIZE'(cin_q);
        carry_d        = cin_q && (dec_q ? (hi_val == '0) : (hi_val == '1));
        done_d         = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      pair_q  <= '0;
      dec_q   <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(REGCOUNT); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      dec_q   <= dec_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  assign busy  = busy_w;
  assign done  = done_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_regpairfile.sv
// Bench for regpairfile: directed vector table, a back-to-back engine
// sequence, then random traffic against a behavioural model.
module tb_regpairfile;
  localparam int D = 8;
  localparam int A = 3;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst, wrenb, wrpair, r1enb, r2enb, rpenb, incenb, decenb;
  logic [2:0]  waddr, r1add, r2add;
  logic [1:0]  rpadd, ipadd;
  logic [15:0] wdata, rpdat;
  logic [7:0]  r1dat, r2dat;
  logic        busy, done, carry;

  always #5 clk = ~clk;

  regpairfile #(.DATASIZE(D), .ADDRSIZE(A), .REGCOUNT(N), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .wrenb(wrenb), .wrpair(wrpair), .waddr(waddr), .wdata(wdata),
    .r1enb(r1enb), .r1add(r1add), .r1dat(r1dat), .r2enb(r2enb), .r2add(r2add),
    .r2dat(r2dat), .rpenb(rpenb), .rpadd(rpadd), .rpdat(rpdat), .incenb(incenb),
    .decenb(decenb), .ipadd(ipadd), .busy(busy), .done(done), .carry(carry)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mem[N];
  int m_step;   // cycles of engine work remaining to be started: 0 idle, 1 low next, 2 high next
  int m_pair;
  bit m_dec;
  int m_res;
  bit m_wrap;
  bit m_carry;
  bit m_done;

  function automatic bit m_wr_ok();
    return wrenb && !(m_step != 0 && (int'(waddr) >> 1) == m_pair);
  endfunction

  function automatic bit m_hits(int a);
    if (wrpair) return (a >> 1) == (int'(waddr) >> 1);
    return a == int'(waddr);
  endfunction

  function automatic int m_wbyte(int a);
    if (wrpair && (a % 2 == 0)) return int'(wdata[15:8]);
    return int'(wdata[7:0]);
  endfunction

  function automatic int m_view(int a);
    if (m_wr_ok() && m_hits(a)) return m_wbyte(a);
    return m_mem[a];
  endfunction

  task automatic m_edge();
    int v;
    bit ok;
    if (!rst) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_step = 0; m_pair = 0; m_dec = 0; m_res = 0; m_wrap = 0; m_carry = 0; m_done = 0;
      return;
    end
    ok = m_wr_ok();
    m_done = 0;
    if (ok) for (int a = 0; a < N; a++) if (m_hits(a)) m_mem[a] = m_wbyte(a);
    if (m_step == 1) begin
      // Whole-pair arithmetic; the low byte lands now, the high byte next edge.
      v = m_mem[2*m_pair] * 256 + m_mem[2*m_pair+1];
      m_res  = m_dec ? (v + 65535) % 65536 : (v + 1) % 65536;
      m_wrap = m_dec ? (v == 0) : (v == 65535);
      m_mem[2*m_pair+1] = m_res % 256;
      m_step = 2;
    end else if (m_step == 2) begin
      m_mem[2*m_pair] = m_res / 256;
      m_carry = m_wrap;
      m_done = 1;
      m_step = 0;
    end else if (incenb ^ decenb) begin
      m_step = 1;
      m_pair = int'(ipadd);
      m_dec  = decenb;
    end
  endtask

  task automatic check_model();
    int e1, e2, ep;
    e1 = r1enb ? m_view(int'(r1add)) : 0;
    e2 = r2enb ? m_view(int'(r2add)) : 0;
    ep = rpenb ? m_view(2*int'(rpadd)) * 256 + m_view(2*int'(rpadd)+1) : 0;
    cmp("m_r1dat", 32'(r1dat), 32'(e1));
    cmp("m_r2dat", 32'(r2dat), 32'(e2));
    cmp("m_rpdat", 32'(rpdat), 32'(ep));
    cmp("m_busy",  32'(busy),  32'(m_step != 0));
    cmp("m_done",  32'(done),  32'(m_done));
    cmp("m_carry", 32'(carry), 32'(m_carry));
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          rst, we, wp;
    logic [2:0]  wa;
    logic [15:0] wd;
    bit          r1e; logic [2:0] r1a;
    bit          r2e; logic [2:0] r2a;
    bit          rpe; logic [1:0] rpa;
    bit          inc, dec; logic [1:0] ipa;
    logic [7:0]  er1, er2;
    logic [15:0] erp;
    bit          eb, ed, ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int rs, int we, int wp, int wa, int wd, int r1e, int r1a,
                             int r2e, int r2a, int rpe, int rpa, int inc, int dec, int ipa,
                             int er1, int er2, int erp, int eb, int ed, int ec);
    vec_t t;
    t.rst = 1'(rs); t.we = 1'(we); t.wp = 1'(wp); t.wa = 3'(wa); t.wd = 16'(wd);
    t.r1e = 1'(r1e); t.r1a = 3'(r1a); t.r2e = 1'(r2e); t.r2a = 3'(r2a);
    t.rpe = 1'(rpe); t.rpa = 2'(rpa); t.inc = 1'(inc); t.dec = 1'(dec); t.ipa = 2'(ipa);
    t.er1 = 8'(er1); t.er2 = 8'(er2); t.erp = 16'(erp);
    t.eb = 1'(eb); t.ed = 1'(ed); t.ec = 1'(ec);
    return t;
  endfunction

  task automatic apply(vec_t t);
    rst = t.rst; wrenb = t.we; wrpair = t.wp; waddr = t.wa; wdata = t.wd;
    r1enb = t.r1e; r1add = t.r1a; r2enb = t.r2e; r2add = t.r2a;
    rpenb = t.rpe; rpadd = t.rpa; incenb = t.inc; decenb = t.dec; ipadd = t.ipa;
  endtask

  task automatic rand_inputs();
    rst    = ($urandom_range(0, 59) != 0);
    wrenb  = $urandom_range(0, 1) == 1;
    wrpair = $urandom_range(0, 1) == 1;
    waddr  = 3'($urandom);
    wdata  = 16'($urandom_range(0, 3) == 0 ? 16'hFFFF - $urandom_range(0, 1) : $urandom);
    r1enb  = $urandom_range(0, 3) != 0; r1add = 3'($urandom);
    r2enb  = $urandom_range(0, 3) != 0; r2add = 3'($urandom);
    rpenb  = $urandom_range(0, 3) != 0; rpadd = 2'($urandom);
    incenb = $urandom_range(0, 3) == 0;
    decenb = $urandom_range(0, 3) == 0;
    ipadd  = 2'($urandom);
  endtask

  bit exp_busy[7] = '{0, 1, 1, 0, 1, 1, 0};
  bit exp_done[7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    vec_t z;
    z = v(0,0,0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
    apply(z);
    tick(); tick();

    // fill with A5, then reset
    vecs.push_back(v(1,1,1,0,'hA5A5, 1,0,0,0,0,0, 0,0,0, 'hA5,0,0, 0,0,0));
    vecs.push_back(v(1,1,1,2,'hA5A5, 0,0,0,0,1,0, 0,0,0, 0,0,'hA5A5, 0,0,0));
    vecs.push_back(v(1,1,1,4,'hA5A5, 0,0,1,3,0,0, 0,0,0, 0,'hA5,0, 0,0,0));
    vecs.push_back(v(1,1,1,6,'hA5A5, 0,0,0,0,1,3, 0,0,0, 0,0,'hA5A5, 0,0,0));
    vecs.push_back(v(0,0,0,0,0,      1,7,1,0,1,1, 0,0,0, 'hA5,'hA5,'hA5A5, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      1,7,1,2,1,2, 0,0,0, 0,0,0, 0,0,0));
    // pair write with same-cycle bypass, then stored read
    vecs.push_back(v(1,1,1,4,'h1234, 1,4,1,5,1,2, 0,0,0, 'h12,'h34,'h1234, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      1,4,1,5,1,2, 0,0,0, 'h12,'h34,'h1234, 0,0,0));
    // increment 00FF -> 0100 (waddr bit 0 ignored for pair writes)
    vecs.push_back(v(1,1,1,3,'h00FF, 0,0,0,0,1,1, 0,0,0, 0,0,'h00FF, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 1,0,1, 0,0,'h00FF, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 0,0,0, 0,0,'h00FF, 1,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 0,0,0, 0,0,'h0000, 1,0,0));
    vecs.push_back(v(1,0,0,0,0,      1,2,1,3,1,1, 0,0,0, 'h01,'h00,'h0100, 0,1,0));
    // increment FFFF -> 0000 with carry
    vecs.push_back(v(1,1,1,2,'hFFFF, 0,0,0,0,1,1, 0,0,0, 0,0,'hFFFF, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 1,0,1, 0,0,'hFFFF, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 0,0,0, 0,0,'hFFFF, 1,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 0,0,0, 0,0,'hFF00, 1,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,1, 0,0,0, 0,0,'h0000, 0,1,1));
    // decrement 0000 -> FFFF
    vecs.push_back(v(1,1,1,6,'h0000, 0,0,0,0,1,3, 0,0,0, 0,0,'h0000, 0,0,1));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,1,3, 0,0,'h0000, 0,0,1));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,0,0, 0,0,'h0000, 1,0,1));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,0,0, 0,0,'h00FF, 1,0,1));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,0,0, 0,0,'hFFFF, 0,1,1));
    // decrement aborted by reset at the LO edge
    vecs.push_back(v(1,1,1,6,'h1200, 0,0,0,0,1,3, 0,0,0, 0,0,'h1200, 0,0,1));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,1,3, 0,0,'h1200, 0,0,1));
    vecs.push_back(v(0,0,0,0,0,      0,0,0,0,1,3, 0,0,0, 0,0,'h1200, 1,0,1));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,0,0, 0,0,'h0000, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,3, 0,0,0, 0,0,'h0000, 0,0,0));
    // conflict: write to reg 1 dropped (no bypass), write to reg 6 stored
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,0, 1,0,0, 0,0,'h0000, 0,0,0));
    vecs.push_back(v(1,1,0,1,'h0077, 1,1,0,0,1,0, 0,0,0, 'h00,0,'h0000, 1,0,0));
    vecs.push_back(v(1,1,0,6,'h0055, 1,1,1,6,1,0, 0,0,0, 'h01,'h55,'h0001, 1,0,0));
    vecs.push_back(v(1,0,0,0,0,      1,1,1,6,1,0, 0,0,0, 'h01,'h55,'h0001, 0,1,0));
    // inc and dec together: no operation
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,0, 1,1,0, 0,0,'h0001, 0,0,0));
    vecs.push_back(v(1,0,0,0,0,      0,0,0,0,1,0, 0,0,0, 0,0,'h0001, 0,0,0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      #3;
      cmp($sformatf("v%0d_r1dat", i), 32'(r1dat), 32'(vecs[i].er1));
      cmp($sformatf("v%0d_r2dat", i), 32'(r2dat), 32'(vecs[i].er2));
      cmp($sformatf("v%0d_rpdat", i), 32'(rpdat), 32'(vecs[i].erp));
      cmp($sformatf("v%0d_busy", i),  32'(busy),  32'(vecs[i].eb));
      cmp($sformatf("v%0d_done", i),  32'(done),  32'(vecs[i].ed));
      cmp($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].ec));
      tick();
    end

    // incenb held high: a new operation starts every 3 cycles
    apply(v(1,0,0,0,0, 0,0,0,0,1,2, 1,0,2, 0,0,0, 0,0,0));
    for (int i = 0; i < 7; i++) begin
      #3;
      cmp($sformatf("b2b%0d_busy", i), 32'(busy), 32'(exp_busy[i]));
      cmp($sformatf("b2b%0d_done", i), 32'(done), 32'(exp_done[i]));
      check_model();
      tick();
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      #3;
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
